// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches one word at a time from ROM over
// req/ack, and presents it to decode over valid/ready with jump and flush redirects.
module fetch_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] jump_addr,
  input  logic        jump,
  input  logic        flush,
  input  logic [15:0] flush_addr,
  output logic        rom_req,
  output logic [15:0] rom_addr,
  input  logic        rom_ack,
  input  logic [15:0] rom_data,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] pc_out,
  input  logic        instr_ready
);

  typedef enum logic {
    REQ  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        discard_q, discard_d;
  logic [15:0] redirect_q, redirect_d;
  logic        rom_req_q, rom_req_d;
  logic [15:0] rom_addr_q, rom_addr_d;
  logic        valid_q, valid_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_q, pc_d;

  logic        ack;
  logic        accept;
  logic [15:0] seq_addr;

  // An ack only counts against a request we actually issued.
  assign ack      = rom_ack & rom_req_q;
  assign accept   = valid_q & instr_ready;
  assign seq_addr = jump ? jump_addr : pc_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    discard_d  = discard_q;
    redirect_d = redirect_q;
    rom_req_d  = rom_req_q;
    rom_addr_d = rom_addr_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;

    unique case (state_q)
      REQ: begin
        if (!rom_req_q) begin
          // Idle cycle right after reset: nothing outstanding, so a flush can retarget directly.
          rom_req_d = 1'b1;
          if (flush) rom_addr_d = flush_addr;
        end else if (ack) begin
          if (flush) begin
            rom_addr_d = flush_addr;
            discard_d  = 1'b0;
          end else if (discard_q) begin
            rom_addr_d = redirect_q;
            discard_d  = 1'b0;
          end else begin
            instr_d   = rom_data;
            pc_d      = rom_addr_q;
            valid_d   = 1'b1;
            rom_req_d = 1'b0;
            state_d   = HOLD;
          end
        end else if (flush) begin
          // The request in flight cannot be withdrawn; remember where to go once it lands.
          discard_d  = 1'b1;
          redirect_d = flush_addr;
        end
      end
      HOLD: begin
        if (flush || accept) begin
          rom_addr_d = flush ? flush_addr : seq_addr;
          rom_req_d  = 1'b1;
          valid_d    = 1'b0;
          state_d    = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= REQ;
      discard_q  <= 1'b0;
      rom_req_q  <= 1'b0;
      rom_addr_q <= RESET_VECTOR;
      valid_q    <= 1'b0;
      instr_q    <= 16'h0000;
      pc_q       <= RESET_VECTOR;
    end else begin
      state_q    <= state_d;
      discard_q  <= discard_d;
      rom_req_q  <= rom_req_d;
      rom_addr_q <= rom_addr_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
    end
  end

  // Pending redirect is only read while discard is set, so it needs no reset.
  always_ff @(posedge clk) begin
    redirect_q <= redirect_d;
  end

  assign rom_req     = rom_req_q;
  assign rom_addr    = rom_addr_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign pc_out      = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, reset corner sequences, then randomized
// traffic checked against a redirect-level model of which address must be delivered next.
module tb_fetch_unit;

  localparam logic [15:0] RV = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] jump_addr;
  logic        jump;
  logic        flush;
  logic [15:0] flush_addr;
  logic        rom_req;
  logic [15:0] rom_addr;
  logic        rom_ack;
  logic [15:0] rom_data;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] pc_out;
  logic        instr_ready;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .rst_n(rst_n), .jump_addr(jump_addr), .jump(jump), .flush(flush),
    .flush_addr(flush_addr), .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack),
    .rom_data(rom_data), .instr_valid(instr_valid), .instr(instr), .pc_out(pc_out),
    .instr_ready(instr_ready)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ready;
    logic        jump;
    logic [15:0] jaddr;
    logic        flush;
    logic [15:0] faddr;
    logic        ack;
    logic [15:0] data;
    logic        ereq;
    logic [15:0] eaddr;
    logic        evld;
    logic [15:0] epc;
    logic [15:0] eins;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t V(input logic rdy, input logic jmp, input logic [15:0] ja,
                             input logic fl, input logic [15:0] fa, input logic ak,
                             input logic [15:0] dt, input logic erq, input logic [15:0] ead,
                             input logic evl, input logic [15:0] epc, input logic [15:0] ein);
    vec_t v;
    v.ready = rdy; v.jump = jmp; v.jaddr = ja; v.flush = fl; v.faddr = fa;
    v.ack = ak; v.data = dt; v.ereq = erq; v.eaddr = ead; v.evld = evl;
    v.epc = epc; v.eins = ein;
    return v;
  endfunction

  function automatic logic [15:0] romf(input logic [15:0] a);
    return a + 16'h0010;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic erq, input logic [15:0] ead,
                         input logic evl, input logic [15:0] epc, input logic [15:0] ein);
    chk({tag, " rom_req"}, {31'd0, rom_req}, {31'd0, erq});
    chk({tag, " rom_addr"}, {16'd0, rom_addr}, {16'd0, ead});
    chk({tag, " instr_valid"}, {31'd0, instr_valid}, {31'd0, evl});
    chk({tag, " pc_out"}, {16'd0, pc_out}, {16'd0, epc});
    chk({tag, " instr"}, {16'd0, instr}, {16'd0, ein});
  endtask

  task automatic idle_inputs();
    instr_ready = 1'b0; jump = 1'b0; jump_addr = '0; flush = 1'b0; flush_addr = '0;
    rom_ack = 1'b0; rom_data = '0;
  endtask

  logic [15:0] exp_pc;
  logic        r_req, r_v, p_req, p_v, p_ready, p_flush, p_ack, p_rst, have_prev;
  logic [15:0] r_addr, r_pc, r_ins, p_addr, p_pc, p_ins;
  int          wcnt, dly;

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    tbl.push_back(V(1,0,0,0,0,0,0,            0,0,0,0,0));
    tbl.push_back(V(1,0,0,0,0,1,'h10,         1,0,0,0,0));
    tbl.push_back(V(1,0,0,0,0,0,0,            0,0,1,0,'h10));
    tbl.push_back(V(1,0,0,0,0,1,'h11,         1,1,0,0,'h10));
    tbl.push_back(V(1,0,0,0,0,0,0,            0,1,1,1,'h11));
    tbl.push_back(V(1,0,0,0,0,1,'h12,         1,2,0,1,'h11));
    tbl.push_back(V(1,0,0,0,0,0,0,            0,2,1,2,'h12));
    tbl.push_back(V(1,0,0,0,0,1,'h13,         1,3,0,2,'h12));
    tbl.push_back(V(1,0,0,0,0,0,0,            0,3,1,3,'h13));
    tbl.push_back(V(1,0,0,0,0,1,'h14,         1,4,0,3,'h13));
    tbl.push_back(V(0,1,'h123,0,0,0,0,        0,4,1,4,'h14));
    tbl.push_back(V(0,1,'h123,0,0,0,0,        0,4,1,4,'h14));
    tbl.push_back(V(0,0,0,0,0,0,0,            0,4,1,4,'h14));
    tbl.push_back(V(0,0,0,0,0,0,0,            0,4,1,4,'h14));
    tbl.push_back(V(0,0,0,0,0,0,0,            0,4,1,4,'h14));
    tbl.push_back(V(1,0,0,0,0,0,0,            0,4,1,4,'h14));
    tbl.push_back(V(1,0,0,0,0,1,'h15,         1,5,0,4,'h14));
    tbl.push_back(V(1,0,0,0,0,0,0,            0,5,1,5,'h15));
    tbl.push_back(V(1,0,0,0,0,1,'h16,         1,6,0,5,'h15));
    tbl.push_back(V(1,0,0,0,0,0,0,            0,6,1,6,'h16));
    tbl.push_back(V(1,0,0,0,0,1,'h17,         1,7,0,6,'h16));
    tbl.push_back(V(1,1,'h123,0,0,0,0,        0,7,1,7,'h17));
    tbl.push_back(V(1,0,0,0,0,1,'h133,        1,'h123,0,7,'h17));
    tbl.push_back(V(1,1,9,0,0,0,0,            0,'h123,1,'h123,'h133));
    tbl.push_back(V(1,0,0,1,'h40,0,0,         1,9,0,'h123,'h133));
    tbl.push_back(V(1,0,0,1,'h50,0,0,         1,9,0,'h123,'h133));
    tbl.push_back(V(1,0,0,0,0,0,0,            1,9,0,'h123,'h133));
    tbl.push_back(V(1,0,0,0,0,1,'h19,         1,9,0,'h123,'h133));
    tbl.push_back(V(1,0,0,0,0,1,'h60,         1,'h50,0,'h123,'h133));
    tbl.push_back(V(1,1,'h200,1,'h300,0,0,    0,'h50,1,'h50,'h60));
    tbl.push_back(V(1,0,0,1,'h400,1,'h310,    1,'h300,0,'h50,'h60));
    tbl.push_back(V(1,0,0,0,0,1,'h410,        1,'h400,0,'h50,'h60));
    tbl.push_back(V(1,1,'hFFFF,0,0,0,0,       0,'h400,1,'h400,'h410));
    tbl.push_back(V(1,0,0,0,0,1,'h000F,       1,'hFFFF,0,'h400,'h410));
    tbl.push_back(V(1,0,0,0,0,0,0,            0,'hFFFF,1,'hFFFF,'h000F));
    tbl.push_back(V(1,0,0,0,0,1,'h10,         1,0,0,'hFFFF,'h000F));
    tbl.push_back(V(0,0,0,1,'h77,0,0,         0,0,1,0,'h10));
    tbl.push_back(V(1,0,0,1,'h88,0,0,         1,'h77,0,0,'h10));
    tbl.push_back(V(1,0,0,1,'h99,1,'h87,      1,'h77,0,0,'h10));
    tbl.push_back(V(1,0,0,0,0,1,'hA9,         1,'h99,0,0,'h10));
    tbl.push_back(V(0,0,0,0,0,0,0,            0,'h99,1,'h99,'hA9));

    @(negedge clk);
    cyc();
    cyc();
    chk_out("reset", 1'b0, RV, 1'b0, RV, 16'h0000);

    foreach (tbl[i]) begin
      chk_out($sformatf("row%0d", i), tbl[i].ereq, tbl[i].eaddr, tbl[i].evld,
              tbl[i].epc, tbl[i].eins);
      rst_n       = 1'b1;
      instr_ready = tbl[i].ready;
      jump        = tbl[i].jump;
      jump_addr   = tbl[i].jaddr;
      flush       = tbl[i].flush;
      flush_addr  = tbl[i].faddr;
      rom_ack     = tbl[i].ack;
      rom_data    = tbl[i].data;
      cyc();
    end

    // Reset while holding an instruction.
    idle_inputs();
    rst_n = 1'b0;
    cyc();
    chk_out("rst_hold", 1'b0, RV, 1'b0, RV, 16'h0000);
    rst_n = 1'b1;
    cyc();
    chk_out("rst_hold_restart", 1'b1, RV, 1'b0, RV, 16'h0000);
    // Reset while a request is outstanding; a coincident ack must be ignored.
    rst_n = 1'b0; rom_ack = 1'b1; rom_data = 16'hBEEF;
    cyc();
    chk_out("rst_req", 1'b0, RV, 1'b0, RV, 16'h0000);
    rst_n = 1'b1; rom_ack = 1'b0;
    cyc();
    chk_out("rst_req_restart", 1'b1, RV, 1'b0, RV, 16'h0000);
    rom_ack = 1'b1; rom_data = romf(RV);
    cyc();
    chk_out("rst_req_fetch", 1'b0, RV, 1'b1, RV, romf(RV));

    // Randomized traffic.
    idle_inputs();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    exp_pc = RV; wcnt = 0; dly = 1; have_prev = 1'b0;
    p_req = 0; p_v = 0; p_ready = 0; p_flush = 0; p_ack = 0; p_rst = 0;
    p_addr = '0; p_pc = '0; p_ins = '0;
    for (int n = 0; n < 4000; n++) begin
      r_req = rom_req; r_addr = rom_addr; r_v = instr_valid; r_pc = pc_out; r_ins = instr;
      if (have_prev) begin
        if (r_v && !p_v) begin
          chk("rand deliver pc", {16'd0, r_pc}, {16'd0, exp_pc});
          chk("rand deliver instr", {16'd0, r_ins}, {16'd0, romf(r_pc)});
        end
        if (p_rst && p_v && !p_ready && !p_flush) begin
          chk("rand hold valid", {31'd0, r_v}, 32'd1);
          chk("rand hold pc", {16'd0, r_pc}, {16'd0, p_pc});
          chk("rand hold instr", {16'd0, r_ins}, {16'd0, p_ins});
        end
        if (p_rst && p_req && !p_ack) begin
          chk("rand req held", {31'd0, r_req}, 32'd1);
          chk("rand addr stable", {16'd0, r_addr}, {16'd0, p_addr});
        end
        chk("rand req_and_valid", {31'd0, r_req & r_v}, 32'd0);
      end

      rst_n       = ($urandom_range(0, 499) != 0);
      instr_ready = ($urandom_range(0, 9) < 7);
      jump        = ($urandom_range(0, 9) < 3);
      jump_addr   = 16'($urandom);
      flush       = ($urandom_range(0, 19) == 0);
      flush_addr  = 16'($urandom);
      rom_ack     = 1'b0;
      rom_data    = 16'($urandom);
      if (!rst_n) begin
        wcnt = 0;
      end else if (r_req) begin
        if (wcnt >= dly) begin
          rom_ack  = 1'b1;
          rom_data = romf(r_addr);
          wcnt     = 0;
          dly      = $urandom_range(0, 3);
        end else begin
          wcnt++;
        end
      end

      if (!rst_n)                  exp_pc = RV;
      else if (flush)              exp_pc = flush_addr;
      else if (r_v && instr_ready) exp_pc = jump ? jump_addr : r_pc + 16'd1;

      p_req = r_req; p_addr = r_addr; p_v = r_v; p_pc = r_pc; p_ins = r_ins;
      p_ready = instr_ready; p_flush = flush; p_ack = rom_ack; p_rst = rst_n;
      have_prev = 1'b1;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the Hack-style CPU.
- Sits directly downstream of the 16-bit jump-target Mux16, which selects between the A register and the ALU output. It consumes that selected address as the branch target.
- Holds the program counter, fetches 16-bit instruction words from instruction ROM over a req/ack handshake, and presents them to decode over a valid/ready handshake.
- Supports taken jumps at instruction retire and asynchronous-to-handshake pipeline flushes.

Parameters:
RESET_VECTOR, 16'h0000, address fetched first after reset and reset value of pc_out/rom_addr

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
jump_addr  input  16  branch target from the upstream Mux16
jump  input  1  current instruction takes the jump; sampled only on an accept cycle
flush  input  1  discard in-flight/held instruction and refetch from flush_addr
flush_addr  input  16  redirect address, sampled when flush=1
rom_req  output  1  fetch request to instruction ROM (registered)
rom_addr  output  16  fetch address (registered), stable while rom_req=1
rom_ack  input  1  ROM completes the request; rom_data valid in the same cycle
rom_data  input  16  instruction word from ROM
instr_valid  output  1  instr holds a valid instruction (registered)
instr  output  16  instruction register
pc_out  output  16  address of the word in instr
instr_ready  input  1  decode accepts instr this cycle

Behaviour:
- Reset (rst_n=0 at an edge):
  - Clears rom_req=0, instr_valid=0, instr=16'h0000.
  - Sets rom_addr=RESET_VECTOR, pc_out=RESET_VECTOR, discard=0.
  - Sets state=REQ.
  - Reset has priority over every other input and aborts any outstanding ROM transaction; the ROM is reset by the same rst_n.
- State machine: states REQ and HOLD, plus an internal discard flag.
- REQ:
  - rom_req=1, instr_valid=0. rom_req rises on the first edge with rst_n=1.
  - rom_req stays high and rom_addr stays constant until a cycle with rom_ack=1.
  - On ack with discard=0 and flush=0: instr<=rom_data, pc_out<=rom_addr, instr_valid<=1, rom_req<=0, state<=HOLD.
  - Latency is 1 cycle: ack in cycle N gives instr_valid=1 in cycle N+1.
- HOLD:
  - instr_valid=1; instr and pc_out are held stable until accept (instr_valid & instr_ready).
  - On accept, the next address is jump_addr if jump=1, else pc_out+1. The increment is modulo 2^16, so 16'hFFFF wraps to 16'h0000.
  - On accept: rom_addr<=next address, rom_req<=1, instr_valid<=0, state<=REQ. The next rom_req is high in the cycle after accept.
  - No fetch is issued while HOLD waits: there is one outstanding ROM request at most and no prefetch.
  - jump is ignored on any cycle without accept.
- Flush, which may arrive in any state:
  - HOLD, no accept: instr_valid<=0, rom_addr<=flush_addr, rom_req<=1, state<=REQ. The held instruction is dropped.
  - HOLD, with accept the same cycle: the instruction counts as consumed, but flush_addr wins over jump_addr and pc_out+1.
  - REQ, rom_ack=0: the ROM request cannot be withdrawn. rom_req stays 1 and rom_addr is unchanged; set discard<=1 and latch flush_addr into a pending redirect register.
  - REQ with discard=1 when ack arrives: rom_data is dropped and instr_valid stays 0. Then rom_addr<=pending redirect, discard<=0, and rom_req stays 1, so a new request starts next cycle.
  - REQ, rom_ack=1 the same cycle as flush: data is dropped and rom_addr<=flush_addr; rom_req stays 1.
  - Repeated flushes while discard=1: the latest flush_addr overwrites the pending redirect.
  - Flush on the same cycle as an ack that has discard=1: flush_addr wins over the pending redirect.
- rom_addr changes only when rom_req=0 or in the cycle after an ack.

Test Plan:
- Reset then linear fetch: RESET_VECTOR=0, ROM acks 1 cycle after req, ROM[0..2]=16'h0010,16'h0011,16'h0012, instr_ready=1 -> instr_valid pulses carry those words with pc_out=0,1,2; rom_addr sequence 0,1,2,3.
- Backpressure: instr_ready=0 for 5 cycles after word at pc 4 -> instr and pc_out held at pc 4, rom_req=0 throughout; ready=1 -> rom_req=1 with rom_addr=5 the next cycle.
- Jump: accept at pc_out=7 with jump=1, jump_addr=16'h0123 -> next rom_addr=16'h0123, next pc_out=16'h0123; jump=1 on a non-accept cycle -> no effect.
- Flush during wait: rom_req at addr 9, flush=1, flush_addr=16'h0040 with ack delayed 3 cycles -> rom_req held at addr 9; data on ack discarded (instr_valid stays 0); next request at 16'h0040; a second flush to 16'h0050 before ack -> 16'h0050 used instead.
- Corner cases: pc_out=16'hFFFF accepted without jump -> rom_addr=16'h0000. flush on the same cycle as accept+jump -> flush_addr used. flush on the same cycle as ack -> word dropped and refetch from flush_addr.
- Reset mid-operation: rst_n=0 during REQ with ack pending and during HOLD -> next cycle rom_req=0, instr_valid=0, pc_out=rom_addr=RESET_VECTOR; fetch restarts cleanly from RESET_VECTOR.
